// File: rtl/branch_cond_unit.sv
// branch_cond_unit: condition-code banks, Bicc evaluation and delay-slot tracking
// for the ID stage. It holds NCC = 2**CC_SEL_W banks of integer condition codes
// and evaluates the 16 Bicc conditions against one selected bank. After each
// accepted branch it tracks the single delay slot and turns the annul bit into
// a squash signal for the delay-slot instruction.
// Optional feature: define CC_BYPASS_EN to forward a same-cycle flag write to
// the branch evaluation. The default build reads the stored bank only.
module branch_cond_unit #(
  parameter int CC_SEL_W = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           stall,
  input  logic                           cc_we,
  input  logic [CC_SEL_W-1:0]            cc_wsel,
  input  logic [3:0]                     cc_wdata,
  input  logic                           br_valid,
  input  logic [3:0]                     br_cond,
  input  logic                           br_annul,
  input  logic [CC_SEL_W-1:0]            br_ccsel,
  output logic                           br_taken,
  output logic                           in_slot,
  output logic                           slot_annul,
  output logic                           dcti_err,
  output logic [4*(2**CC_SEL_W)-1:0]     cc_q
);

  localparam int NCC = 2**CC_SEL_W;

  typedef enum logic {IDLE, SLOT} state_t;

  state_t                state_q, state_d;
  logic [NCC-1:0][3:0]   bank_q;
  logic [3:0]            flags;
  logic                  cond_result;
  logic                  acc;
  logic                  annul_dec;
  logic                  annul_d;
  logic                  dcti_d;

  // Flag layout: bit0 Z, bit1 N, bit2 C, bit3 V. cond[3] inverts the base test,
  // so 1000 (always) is simply the inverse of 0000 (never).
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic z, n, c, v, base;
    z = f[0];
    n = f[1];
    c = f[2];
    v = f[3];
    case (cond[2:0])
      3'b000:  base = 1'b0;
      3'b001:  base = z;
      3'b010:  base = z | (n ^ v);
      3'b011:  base = n ^ v;
      3'b100:  base = c | z;
      3'b101:  base = c;
      3'b110:  base = n;
      default: base = v;
    endcase
    return base ^ cond[3];
  endfunction

  // Condition-code banks; writes are independent of the pipeline stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q <= '0;
    end else if (cc_we) begin
      bank_q[cc_wsel] <= cc_wdata;
    end
  end

  assign cc_q = bank_q;

  // Select the flags evaluated by the branch in ID.
  always_comb begin
`ifdef CC_BYPASS_EN
    if (cc_we && (cc_wsel == br_ccsel)) flags = cc_wdata;
    else                                flags = bank_q[br_ccsel];
`else
    flags = bank_q[br_ccsel];
`endif
  end

  assign cond_result = cond_eval(br_cond, flags);

  // A branch is accepted only outside a delay slot and while ID advances.
  assign acc      = br_valid & ~stall & (state_q == IDLE);
  assign br_taken = acc & cond_result;

  // ba,a and bn,a always annul; other conditions with a=1 annul when not taken.
  assign annul_dec = br_annul & ((br_cond[2:0] == 3'b000) | ~cond_result);

  // Delay-slot FSM state and registered slot/error outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      slot_annul <= 1'b0;
      dcti_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_annul <= annul_d;
      dcti_err   <= dcti_d;
    end
  end

  assign in_slot = (state_q == SLOT);

  // Next state: enter SLOT on acceptance, leave on the first unstalled slot
  // cycle. A branch in a non-annulled slot is a DCTI couple and is flagged.
  always_comb begin
    state_d = state_q;
    annul_d = slot_annul;
    dcti_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = SLOT;
          annul_d = annul_dec;
        end
      end
      SLOT: begin
        if (!stall) begin
          state_d = IDLE;
          annul_d = 1'b0;
          dcti_d  = br_valid & ~slot_annul;
        end
      end
      default: begin
        state_d = IDLE;
        annul_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed testbench for branch_cond_unit (CC_SEL_W = 1, two banks).
module tb_branch_cond_unit;

  logic       clk;
  logic       reset_n;
  logic       stall;
  logic       cc_we;
  logic [0:0] cc_wsel;
  logic [3:0] cc_wdata;
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_annul;
  logic [0:0] br_ccsel;
  logic       br_taken;
  logic       in_slot;
  logic       slot_annul;
  logic       dcti_err;
  logic [7:0] cc_q;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  branch_cond_unit #(.CC_SEL_W(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .cc_we      (cc_we),
    .cc_wsel    (cc_wsel),
    .cc_wdata   (cc_wdata),
    .br_valid   (br_valid),
    .br_cond    (br_cond),
    .br_annul   (br_annul),
    .br_ccsel   (br_ccsel),
    .br_taken   (br_taken),
    .in_slot    (in_slot),
    .slot_annul (slot_annul),
    .dcti_err   (dcti_err),
    .cc_q       (cc_q)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] tbl_cond [10];
  logic       tbl_exp  [10];
  logic       exp_bypass;

  initial begin
    reset_n  = 1'b0;
    stall    = 1'b0;
    cc_we    = 1'b0;
    cc_wsel  = '0;
    cc_wdata = 4'h0;
    br_valid = 1'b0;
    br_cond  = 4'h0;
    br_annul = 1'b0;
    br_ccsel = '0;

    // Reset state
    tick();
    tick();
    chk("rst_cc_q", cc_q, 8'h00);
    chk("rst_in_slot", in_slot, 1'b0);
    chk("rst_slot_annul", slot_annul, 1'b0);
    chk("rst_dcti_err", dcti_err, 1'b0);
    chk("rst_br_taken", br_taken, 1'b0);
    reset_n = 1'b1;
    tick();

    // Bank 0 = Z
    cc_we = 1'b1; cc_wsel = 1'b0; cc_wdata = 4'b0001;
    tick();
    cc_we = 1'b0;
    chk("wr_bank0_z", cc_q, 8'h01);
    br_valid = 1'b1; br_ccsel = 1'b0; br_annul = 1'b0; br_cond = 4'b1001;
    #1 chk("bne_z_set", br_taken, 1'b0);
    br_cond = 4'b0001;
    #1 chk("be_z_set", br_taken, 1'b1);
    tick();
    chk("be_in_slot", in_slot, 1'b1);
    chk("be_slot_annul", slot_annul, 1'b0);
    br_valid = 1'b0;
    tick();
    chk("be_slot_done", in_slot, 1'b0);

    // Bank 0 = V,N set: bge,a taken, bl,a not taken
    cc_we = 1'b1; cc_wdata = 4'b1010;
    tick();
    cc_we = 1'b0;
    br_valid = 1'b1; br_cond = 4'b1011; br_annul = 1'b1;
    #1 chk("bge_a_taken", br_taken, 1'b1);
    tick();
    br_valid = 1'b0;
    chk("bge_a_in_slot", in_slot, 1'b1);
    chk("bge_a_annul", slot_annul, 1'b0);
    tick();
    br_valid = 1'b1; br_cond = 4'b0011; br_annul = 1'b1;
    #1 chk("bl_a_taken", br_taken, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("bl_a_annul", slot_annul, 1'b1);
    tick();
    chk("bl_a_slot_clr", slot_annul, 1'b0);

    // ba,a and bn,a
    br_valid = 1'b1; br_cond = 4'b1000; br_annul = 1'b1;
    #1 chk("ba_a_taken", br_taken, 1'b1);
    tick();
    br_valid = 1'b0;
    chk("ba_a_annul", slot_annul, 1'b1);
    tick();
    br_valid = 1'b1; br_cond = 4'b0000; br_annul = 1'b1;
    #1 chk("bn_a_taken", br_taken, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("bn_a_annul", slot_annul, 1'b1);
    tick();

    // Remaining conditions against Z=0 N=1 C=0 V=1, within one idle cycle
    tbl_cond[0] = 4'b0110; tbl_exp[0] = 1'b1;
    tbl_cond[1] = 4'b0101; tbl_exp[1] = 1'b0;
    tbl_cond[2] = 4'b0100; tbl_exp[2] = 1'b0;
    tbl_cond[3] = 4'b1100; tbl_exp[3] = 1'b1;
    tbl_cond[4] = 4'b0010; tbl_exp[4] = 1'b0;
    tbl_cond[5] = 4'b1010; tbl_exp[5] = 1'b1;
    tbl_cond[6] = 4'b0111; tbl_exp[6] = 1'b1;
    tbl_cond[7] = 4'b1111; tbl_exp[7] = 1'b0;
    tbl_cond[8] = 4'b1101; tbl_exp[8] = 1'b1;
    tbl_cond[9] = 4'b1110; tbl_exp[9] = 1'b0;
    br_valid = 1'b1; br_annul = 1'b0;
    for (int i = 0; i < 10; i++) begin
      br_cond = tbl_cond[i];
      #1 chk($sformatf("cond_%b", tbl_cond[i]), br_taken, tbl_exp[i]);
    end
    br_valid = 1'b0;
    tick();

    // DCTI couple: branch in a non-annulled slot
    br_valid = 1'b1; br_cond = 4'b1000; br_annul = 1'b0;
    tick();
    chk("dcti_in_slot", in_slot, 1'b1);
    #1 chk("dcti_br_taken", br_taken, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("dcti_err_pulse", dcti_err, 1'b1);
    chk("dcti_back_idle", in_slot, 1'b0);
    tick();
    chk("dcti_err_clear", dcti_err, 1'b0);

    // Branch in an annulled slot: ignored silently
    br_valid = 1'b1; br_cond = 4'b1000; br_annul = 1'b1;
    tick();
    chk("annslot_annul", slot_annul, 1'b1);
    #1 chk("annslot_br_taken", br_taken, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("annslot_no_err", dcti_err, 1'b0);
    chk("annslot_back_idle", in_slot, 1'b0);
    tick();

    // Same-cycle write to bank 1 and branch on bank 1 (stored bank 1 = 0)
`ifdef CC_BYPASS_EN
    exp_bypass = 1'b1;
`else
    exp_bypass = 1'b0;
`endif
    cc_we = 1'b1; cc_wsel = 1'b1; cc_wdata = 4'b0001;
    br_valid = 1'b1; br_ccsel = 1'b1; br_cond = 4'b0001; br_annul = 1'b0;
    #1 chk("bypass_br_taken", br_taken, exp_bypass);
    tick();
    cc_we = 1'b0; br_valid = 1'b0;
    chk("bank1_written", cc_q, 8'h1A);
    tick();

    // Stall holds the slot; async reset mid-slot clears everything
    br_valid = 1'b1; br_ccsel = 1'b0; br_cond = 4'b1000; br_annul = 1'b1;
    tick();
    br_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_in_slot_%0d", i), in_slot, 1'b1);
    end
    chk("stall_slot_annul", slot_annul, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("arst_in_slot", in_slot, 1'b0);
    chk("arst_slot_annul", slot_annul, 1'b0);
    chk("arst_cc_q", cc_q, 8'h00);
    tick();
    reset_n = 1'b1; stall = 1'b0;
    tick();
    chk("post_rst_in_slot", in_slot, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
